// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 round-robin stream multiplexer.
//   MODE_RR / MODE_FIXED : arbitration mode selectors for mux_nx1_rr.MODE
//   clog2_safe()         : index width that never collapses to zero bits
package mux_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  // Width of an index field able to address n entries (at least one bit).
  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req       : request vector, one bit per channel
//   ptr       : channel that has highest priority this cycle
//   gnt_valid : some request is granted
//   gnt_idx   : granted channel, first requester found scanning ptr upward
//               with wrap-around (tie ptr to 0 for lowest-index priority)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned SELW = clog2_safe(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      int unsigned     pos;
      logic [SELW-1:0] idx;
      pos = 32'(ptr) + 32'(k);
      if (pos >= N) begin
        pos = pos - N;
      end
      idx = SELW'(pos);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-input registered stream multiplexer with valid/ready handshakes.
// Arbitration is round-robin (MODE_RR) or lowest-index-first (MODE_FIXED);
// force_en restricts eligibility to the single channel force_sel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid    : N channels, channel i at in_data[i*W +: W]
//   in_ready            : one-hot (or zero) acceptance, combinational
//   force_en/force_sel  : manual channel selection
//   out_data/out_valid  : registered output word and its valid flag
//   out_ready           : consumer accepts out_data this cycle
//   out_sel             : channel that supplied out_data
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = MODE_RR,
  localparam int unsigned SELW = clog2_safe(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel
);

  logic [W-1:0]    chan_data [N];
  logic [N-1:0]    elig_c;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] arb_ptr_c;
  logic            gnt_valid_c;
  logic [SELW-1:0] gnt_idx_c;
  logic            load_en_c;
  logic            xfer_c;

  // Unpack the flat data bus into per-channel words.
  for (genvar i = 0; i < int'(N); i++) begin : g_unpack
    assign chan_data[i] = in_data[i*W +: W];
  end

  // Eligible set: all valid channels, or only the forced one if it is in range.
  always_comb begin
    elig_c = '0;
    if (!force_en) begin
      elig_c = in_valid;
    end else if (32'(force_sel) < N) begin
      elig_c[force_sel] = in_valid[force_sel];
    end
  end

  // Fixed priority is round-robin with the pointer pinned at channel 0.
  assign arb_ptr_c = (MODE == MODE_FIXED) ? '0 : ptr;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req       (elig_c),
    .ptr       (arb_ptr_c),
    .gnt_valid (gnt_valid_c),
    .gnt_idx   (gnt_idx_c)
  );

  // Output register can take a word when empty or being drained this cycle.
  assign load_en_c = !out_valid || out_ready;
  assign xfer_c    = rst_n && load_en_c && gnt_valid_c;
  assign in_ready  = xfer_c ? (N'(1) << gnt_idx_c) : '0;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (xfer_c) begin
        out_valid <= 1'b1;
        out_data  <= chan_data[gnt_idx_c];
        out_sel   <= gnt_idx_c;
        if (MODE == MODE_RR) begin
          ptr <= (32'(gnt_idx_c) == N - 1) ? '0 : gnt_idx_c + SELW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: one round-robin and one fixed-priority
// instance share all inputs and are compared against a behavioural model.
module tb_mux_nx1_rr;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned SELW = 2;

  logic            clk;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic            force_en;
  logic [SELW-1:0] force_sel;
  logic            out_ready;

  logic [N-1:0]    rdy_rr, rdy_fx;
  logic [W-1:0]    od_rr, od_fx;
  logic            ov_rr, ov_fx;
  logic [SELW-1:0] os_rr, os_fx;

  int errors = 0;
  int checks = 0;

  mux_nx1_rr #(.N(N), .W(W), .MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_rr), .force_en(force_en), .force_sel(force_sel),
    .out_data(od_rr), .out_valid(ov_rr), .out_ready(out_ready), .out_sel(os_rr)
  );

  mux_nx1_rr #(.N(N), .W(W), .MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_fx), .force_en(force_en), .force_sel(force_sel),
    .out_data(od_fx), .out_valid(ov_fx), .out_ready(out_ready), .out_sel(os_fx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  bit       m_valid [2] = '{0, 0};
  int       m_data  [2] = '{0, 0};
  int       m_sel   [2] = '{0, 0};
  int       m_ptr   [2] = '{0, 0};

  // Pick the eligible channel at the smallest priority distance from ptr.
  function automatic void model_grant(input int mode, input int ptr,
                                      input logic [N-1:0] v, input logic fen,
                                      input int fsel, output bit ok, output int g);
    int best;
    ok = 0;
    g = 0;
    best = N;
    for (int i = 0; i < N; i++) begin
      bit e;
      int d;
      e = fen ? (i == fsel && v[i]) : v[i];
      d = (mode == 0) ? (i - ptr + N) % N : i;
      if (e && d < best) begin
        best = d;
        g = i;
        ok = 1;
      end
    end
  endfunction

  function automatic int exp_ready(input int j);
    bit ok;
    int g;
    model_grant(j, m_ptr[j], in_valid, force_en, int'(force_sel), ok, g);
    if (rst_n && ok && (!m_valid[j] || out_ready)) return 1 << g;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        m_valid[j] <= 0;
        m_data[j]  <= 0;
        m_sel[j]   <= 0;
        m_ptr[j]   <= 0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        bit ok;
        int g;
        model_grant(j, m_ptr[j], in_valid, force_en, int'(force_sel), ok, g);
        if (ok && (!m_valid[j] || out_ready)) begin
          m_valid[j] <= 1;
          m_data[j]  <= int'(in_data[g*W +: W]);
          m_sel[j]   <= g;
          if (j == 0) m_ptr[j] <= (g == N - 1) ? 0 : g + 1;
        end else if (out_ready) begin
          m_valid[j] <= 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("rr_out_valid", int'(ov_rr), int'(m_valid[0]));
    check("rr_out_data",  int'(od_rr), m_data[0]);
    check("rr_out_sel",   int'(os_rr), m_sel[0]);
    check("rr_in_ready",  int'(rdy_rr), exp_ready(0));
    check("fx_out_valid", int'(ov_fx), int'(m_valid[1]));
    check("fx_out_data",  int'(od_fx), m_data[1]);
    check("fx_out_sel",   int'(os_fx), m_sel[1]);
    check("fx_in_ready",  int'(rdy_fx), exp_ready(1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_chan(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    force_en  = 1'b0;
    force_sel = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_chan(i, 8'hA0 + 8'(i));

    // Reset with every channel requesting.
    tick();
    tick();
    check("rst_out_valid", int'(ov_rr), 0);
    check("rst_out_data",  int'(od_rr), 0);
    check("rst_out_sel",   int'(os_rr), 0);
    check("rst_in_ready",  int'(rdy_rr), 0);
    check("rst_fx_in_ready", int'(rdy_fx), 0);
    rst_n = 1'b1;

    // Round-robin rotation at full throughput.
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_seq_sel",  int'(os_rr), k % 4);
      check("rr_seq_data", int'(od_rr), 'hA0 + k % 4);
      check("rr_seq_valid", int'(ov_rr), 1);
      check("fx_seq_sel",  int'(os_fx), 0);
    end

    // Backpressure holds the loaded word.
    set_chan(0, 8'h5C);
    tick();
    check("bp_load", int'(od_rr), 'h5C);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", int'(rdy_rr), 0);
      tick();
      check("bp_hold_data",  int'(od_rr), 'h5C);
      check("bp_hold_valid", int'(ov_rr), 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy_rr", int'(rdy_rr), 'b0010);
    check("bp_release_rdy_fx", int'(rdy_fx), 'b0001);
    tick();
    check("bp_release_sel", int'(os_rr), 1);

    // Force mode on channel 2.
    force_en  = 1'b1;
    force_sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("force_rdy", int'(rdy_rr), 'b0100);
      tick();
      check("force_sel_rr", int'(os_rr), 2);
      check("force_sel_fx", int'(os_fx), 2);
    end
    force_sel = 2'd3;
    in_valid  = 4'b0111;
    #1;
    check("force_idle_rdy", int'(rdy_rr), 0);
    tick();
    check("force_idle_valid", int'(ov_rr), 0);
    force_en = 1'b0;

    // Fixed priority starves channel 2 while channel 1 is valid.
    in_valid = 4'b0110;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fixed_rdy", int'(rdy_fx), 'b0010);
      tick();
      check("fixed_sel", int'(os_fx), 1);
    end

    // Asynchronous reset while a word is held.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    tick();
    check("midrst_pre_valid", int'(ov_rr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_rr", int'(ov_rr), 0);
    check("midrst_valid_fx", int'(ov_fx), 0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_chan(i, 8'hA0 + 8'(i));
    tick();
    check("midrst_first_sel", int'(os_rr), 0);
    check("midrst_first_data", int'(od_rr), 'hA0);

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      force_en  = ($urandom_range(0, 7) == 0);
      force_sel = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) set_chan(i, 8'($urandom));
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
